// File: rtl/fwd_scoreboard_if.sv
// fwd_scoreboard_if: decode-side controls and
// forward/stall results of the hazard unit.
interface fwd_scoreboard_if #(
  parameter int NREGS = 32,
  parameter int NSRC  = 2,
  parameter int DEPTH = 3
);
  localparam int RW = $clog2(NREGS);
  localparam int SW = $clog2(DEPTH);

  logic              en;
  logic              flush;
  logic              id_valid;
  logic              id_wen;
  logic              id_load;
  logic [RW-1:0]     id_wsel;
  logic [NSRC*RW-1:0] id_rsel;
  logic [NSRC*SW-1:0] fwd_sel;
  logic              stall;
  logic [31:0]       stall_count;

  modport master (
    output en, flush, id_valid, id_wen,
    output id_load, id_wsel, id_rsel,
    input  fwd_sel, stall, stall_count
  );

  modport slave (
    input  en, flush, id_valid, id_wen,
    input  id_load, id_wsel, id_rsel,
    output fwd_sel, stall, stall_count
  );
endinterface

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: shift-register scoreboard of
// in-flight writers, EX forward selects, load-use stall.
module fwd_scoreboard #(
  parameter int NREGS      = 32,
  parameter int NSRC       = 2,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 2
) (
  input logic              CLK,
  input logic              nRST,
  fwd_scoreboard_if.slave  bus
);
  localparam int RW = $clog2(NREGS);
  localparam int SW = $clog2(DEPTH);

  logic [DEPTH-1:0]   vld_q, vld_d;
  logic [DEPTH-1:0]   wen_q, wen_d;
  logic [DEPTH-1:0]   ld_q, ld_d;
  logic [RW-1:0]      wsel_q [DEPTH];
  logic [RW-1:0]      wsel_d [DEPTH];
  logic [NSRC*RW-1:0] ex_rsel_q, ex_rsel_d;
  logic [31:0]        cnt_q, cnt_d;

  logic [NSRC*SW-1:0] fwd;
  logic               stall;

  // EX operand select: scan oldest to youngest so the
  // youngest matching producer overwrites the others.
  always_comb begin
    fwd = '0;
    for (int s = 0; s < NSRC; s++) begin
      for (int k = DEPTH-1; k >= 1; k--) begin
        if (vld_q[k] && wen_q[k] &&
            wsel_q[k] != '0 &&
            wsel_q[k] == ex_rsel_q[s*RW +: RW]) begin
          fwd[s*SW +: SW] = SW'(k);
        end
      end
    end
  end

  // Decode stall: youngest matching producer decides,
  // stall if its data is not forwardable next cycle.
  always_comb begin
    logic sv;
    stall = 1'b0;
    for (int s = 0; s < NSRC; s++) begin
      sv = 1'b0;
      if (bus.id_valid) begin
        for (int k = DEPTH-2; k >= 0; k--) begin
          if (vld_q[k] && wen_q[k] &&
              wsel_q[k] != '0 &&
              wsel_q[k] == bus.id_rsel[s*RW +: RW]) begin
            sv = ((k + 1) <
                  (ld_q[k] ? LOAD_READY : 1));
          end
        end
      end
      stall = stall | sv;
    end
  end

  // Advance the scoreboard and count stall bubbles.
  always_comb begin
    vld_d     = vld_q;
    wen_d     = wen_q;
    ld_d      = ld_q;
    wsel_d    = wsel_q;
    ex_rsel_d = ex_rsel_q;
    cnt_d     = cnt_q;
    if (bus.en) begin
      for (int k = DEPTH-1; k >= 1; k--) begin
        vld_d[k]  = vld_q[k-1];
        wen_d[k]  = wen_q[k-1];
        ld_d[k]   = ld_q[k-1];
        wsel_d[k] = wsel_q[k-1];
      end
      if (bus.flush || stall) begin
        vld_d[0]  = 1'b0;
        wen_d[0]  = 1'b0;
        ld_d[0]   = 1'b0;
        wsel_d[0] = '0;
        ex_rsel_d = '0;
      end else begin
        vld_d[0]  = bus.id_valid;
        wen_d[0]  = bus.id_wen;
        ld_d[0]   = bus.id_load;
        wsel_d[0] = bus.id_wsel;
        ex_rsel_d = bus.id_rsel;
      end
      if (stall && !bus.flush &&
          cnt_q != 32'hFFFF_FFFF) begin
        cnt_d = cnt_q + 32'd1;
      end
    end
  end

  // State registers, cleared by async reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      vld_q     <= '0;
      wen_q     <= '0;
      ld_q      <= '0;
      ex_rsel_q <= '0;
      cnt_q     <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        wsel_q[k] <= '0;
      end
    end else begin
      vld_q     <= vld_d;
      wen_q     <= wen_d;
      ld_q      <= ld_d;
      ex_rsel_q <= ex_rsel_d;
      cnt_q     <= cnt_d;
      for (int k = 0; k < DEPTH; k++) begin
        wsel_q[k] <= wsel_d[k];
      end
    end
  end

  assign bus.fwd_sel     = fwd;
  assign bus.stall       = stall;
  assign bus.stall_count = cnt_q;
endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb_fwd_scoreboard: directed vector table plus
// hand sequences for reset and mid-stall reset.
module tb_fwd_scoreboard;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  fwd_scoreboard_if #(
    .NREGS(32), .NSRC(2), .DEPTH(3)
  ) bus ();

  fwd_scoreboard #(
    .NREGS(32), .NSRC(2),
    .DEPTH(3), .LOAD_READY(2)
  ) dut (
    .CLK  (clk),
    .nRST (rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic       en, fl, v, w, ld;
    logic [4:0] wd, r0, r1;
    logic [1:0] f0, f1;
    logic       st;
    int         cnt;
  } vec_t;

  vec_t tv[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic drv(input logic en, fl, v, w, ld,
                     input logic [4:0] wd, r0, r1);
    bus.en       = en;
    bus.flush    = fl;
    bus.id_valid = v;
    bus.id_wen   = w;
    bus.id_load  = ld;
    bus.id_wsel  = wd;
    bus.id_rsel  = {r1, r0};
  endtask

  task automatic V(input logic en, fl, v, w, ld,
                   input logic [4:0] wd, r0, r1,
                   input logic [1:0] f0, f1,
                   input logic st, input int cnt);
    vec_t t;
    t.en = en; t.fl = fl; t.v = v;
    t.w = w; t.ld = ld; t.wd = wd;
    t.r0 = r0; t.r1 = r1;
    t.f0 = f0; t.f1 = f1; t.st = st;
    t.cnt = cnt;
    tv.push_back(t);
  endtask

  task automatic nop(input logic [1:0] f0, f1,
                     input int cnt);
    V(1,0,0,0,0, 0,0,0, f0,f1,0,cnt);
  endtask

  // A forwarded load must come from an entry
  // at or beyond the load-ready index.
  always @(negedge clk) begin
    #4;
    if (rst_n) begin
      for (int s = 0; s < 2; s++) begin
        int k;
        k = int'(bus.fwd_sel[s*2 +: 2]);
        if (k != 0) begin
          total++;
          if (dut.ld_q[k] && k < 2) begin
            bad++;
            $display("FAIL inv op%0d: got %0d want >=2",
                     s, k);
          end
        end
      end
    end
  end

  initial begin
    drv(0,0,0,0,0, 0,0,0);

    repeat (3) begin
      @(negedge clk);
      drv(1'($urandom), 1'($urandom),
          1'($urandom), 1'($urandom),
          1'($urandom), 5'($urandom),
          5'($urandom), 5'($urandom));
      #2;
      chk("rst fwd", 32'(bus.fwd_sel), 0);
      chk("rst stall", 32'(bus.stall), 0);
      chk("rst cnt", bus.stall_count, 0);
    end
    drv(1,0,0,0,0, 0,0,0);
    @(negedge clk);
    rst_n = 1'b1;

    // ALU distance 1
    V(1,0,1,0,0, 0,5,0,  0,0,0,0);
    V(1,0,1,1,0, 5,0,0,  0,0,0,0);
    V(1,0,1,0,0, 0,5,0,  0,0,0,0);
    nop(1,0,0);
    // ALU distance 2
    V(1,0,1,1,0, 5,0,0,  0,0,0,0);
    nop(0,0,0);
    V(1,0,1,0,0, 0,5,0,  0,0,0,0);
    nop(2,0,0);
    // ALU distance 3
    V(1,0,1,1,0, 5,0,0,  0,0,0,0);
    nop(0,0,0);
    nop(0,0,0);
    V(1,0,1,0,0, 0,5,0,  0,0,0,0);
    nop(0,0,0);
    // load-use
    V(1,0,1,1,1, 7,0,0,  0,0,0,0);
    V(1,0,1,0,0, 0,0,7,  0,0,1,0);
    V(1,0,1,0,0, 0,0,7,  0,0,0,1);
    nop(0,2,1);
    // youngest of two r3 writers
    V(1,0,1,1,0, 3,0,0,  0,0,0,1);
    V(1,0,1,1,0, 3,0,0,  0,0,0,1);
    V(1,0,1,0,0, 0,3,3,  0,0,0,1);
    nop(1,1,1);
    // r0 never matches
    V(1,0,1,1,1, 0,0,0,  0,0,0,1);
    V(1,0,1,0,0, 0,0,0,  0,0,0,1);
    nop(0,0,1);
    // freeze during load-use stall
    V(1,0,1,1,1, 9,0,0,  0,0,0,1);
    repeat (4) V(0,0,1,0,0, 0,9,0, 0,0,1,1);
    V(1,0,1,0,0, 0,9,0,  0,0,1,1);
    V(1,0,1,0,0, 0,9,0,  0,0,0,2);
    nop(2,0,2);
    // flush with stall-causing consumer
    V(1,0,1,1,1, 11,0,0, 0,0,0,2);
    V(1,1,1,1,0, 12,11,0, 0,0,1,2);
    V(1,0,1,0,0, 0,12,11, 0,0,0,2);
    nop(0,2,2);

    foreach (tv[i]) begin
      @(negedge clk);
      drv(tv[i].en, tv[i].fl, tv[i].v, tv[i].w,
          tv[i].ld, tv[i].wd, tv[i].r0, tv[i].r1);
      #2;
      chk($sformatf("v%0d fwd0", i),
          32'(bus.fwd_sel[1:0]), 32'(tv[i].f0));
      chk($sformatf("v%0d fwd1", i),
          32'(bus.fwd_sel[3:2]), 32'(tv[i].f1));
      chk($sformatf("v%0d stall", i),
          32'(bus.stall), 32'(tv[i].st));
      chk($sformatf("v%0d cnt", i),
          bus.stall_count, 32'(tv[i].cnt));
    end

    // reset asserted mid-stall
    @(negedge clk);
    drv(1,0,1,1,1, 7,0,0);
    @(negedge clk);
    drv(1,0,1,0,0, 0,0,7);
    #2;
    chk("pre-rst stall", 32'(bus.stall), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid-rst stall", 32'(bus.stall), 0);
    chk("mid-rst cnt", bus.stall_count, 0);
    chk("mid-rst fwd", 32'(bus.fwd_sel), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("post-rst stall", 32'(bus.stall), 0);
    @(negedge clk);
    drv(1,0,0,0,0, 0,0,0);
    #2;
    chk("post-rst fwd1", 32'(bus.fwd_sel[3:2]), 0);
    chk("post-rst cnt", bus.stall_count, 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end
endmodule
